id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS32 pipeline, directly upstream of EX.
- Decodes the IF/ID instruction and drives the register file read addresses (rd1/rd2).
- Captures the returned operands (A/B) plus decoded control into the ID/EX pipeline register.
- Detects load-use hazards (stall IF/ID, inject bubble) and honours branch flushes from EX.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous active-low reset.
- if_id_valid  in  1  IF/ID holds a real instruction.
- if_id_instr  in  32  instruction word.
- if_id_pc4  in  32  PC+4 of that instruction.
- flush  in  1  EX resolved a taken branch; squash the ID instruction.
- rf_rd1  out  5  register file read address 1 (rs), combinational.
- rf_rd2  out  5  register file read address 2 (rt), combinational.
- rf_A  in  32  register file read data 1.
- rf_B  in  32  register file read data 2.
- stall_if  out  1  hold PC and IF/ID this cycle, combinational.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_A, ex_B  out  32 each  latched operands.
- ex_imm  out  32  extended immediate, or shamt.
- ex_rs, ex_rt  out  5 each  source register numbers, for forwarding.
- ex_dst  out  5  destination register.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch  out  1 each  control.
- ex_aluop  out  3  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL.
- ex_pc4  out  32  latched PC+4.
- ex_illegal  out  1  unsupported opcode/funct latched this cycle.
- stall_count  out  STALL_CNT_W  saturating count of load-use stalls.

Behaviour:
- rf_rd1 = instr[25:21] and rf_rd2 = instr[20:16], always, regardless of valid.
- Register file writes on negedge; a same-cycle WB write is visible on rf_A/rf_B before posedge. No internal WB bypass.
- Decode table (op/funct in hex):
  - R-type op 00: funct 20 ADD, 22 SUB, 24 AND, 25 OR, 2A SLT, 00 SLL (imm = {27'b0, shamt}); dst = rd; regwrite = 1.
  - addi 08: sign-extend, alusrc, ADD, dst = rt.
  - andi 0C / ori 0D: zero-extend, alusrc, AND/OR, dst = rt.
  - lw 23: sign-extend, ADD, alusrc, memread, memtoreg, dst = rt.
  - sw 2B: sign-extend, ADD, alusrc, memwrite, dst = 0.
  - beq 04: sign-extend, SUB, branch, dst = 0.
  - Anything else: all control 0, dst 0, ex_illegal = 1 (when valid).
- regwrite is forced 0 when dst == 0.
- Load-use hazard = if_id_valid & ex_valid & ex_memread & ex_dst != 0 & (ex_dst == rs | (ex_dst == rt & instruction reads rt)).
  - Instructions that read rt: R-type, sw, beq.
- Posedge update, in priority order:
  1. rst_n = 0: every registered output becomes 0 (ex_valid 0, all control 0, data 0, stall_count 0).
  2. flush: bubble (ex_valid and all control/illegal 0; data fields don't-care, implement as 0); stall_if = 0.
  3. hazard: bubble; stall_if = 1; stall_count increments, saturating at all-ones.
  4. otherwise: latch the decode; ex_valid = if_id_valid; if invalid, control = 0.
- stall_if = hazard & ~flush & rst_n, combinational.
- A stall lasts exactly one cycle: the injected bubble clears ex_memread.
- Reset asserted mid-stall clears everything; no stall on the first cycle after reset.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with a valid addi present -> all ex_* = 0, stall_if = 0, stall_count = 0.
- addi $3,$1,-4 (0x2023FFFC), rf_A = 8 -> next cycle ex_A = 8, ex_imm = 0xFFFFFFFC, ex_dst = 3, ex_regwrite = 1, ex_alusrc = 1, ex_aluop = 0.
- ori $4,$2,0x8001 -> ex_imm = 0x00008001, ex_aluop = 3, ex_dst = 4.
- lw $5,0($1) then add $6,$5,$2 -> stall_if = 1 for exactly 1 cycle, bubble in ID/EX, add latched on the following cycle, stall_count = 1.
- lw $0,0($1) then add $6,$0,$2 -> no stall.
- lw $5 then sw $5,4($1) -> stall (rt read).
- lw $5 then addi $5,$1,1 -> no stall (rt not read).
- Hazard and flush asserted in the same cycle -> stall_if = 0, bubble latched, stall_count unchanged.
- Opcode 0x3F -> ex_illegal = 1 for 1 cycle, ex_regwrite = 0.
- sll $7,$2,3 -> ex_imm = 3, ex_aluop = 5, ex_dst = 7.

Source files
------------

// File: rtl/id_ex_stage.sv
// MIPS32 instruction-decode stage: decodes IF/ID, drives register file reads,
// detects load-use hazards and fills the ID/EX pipeline register.
module id_ex_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_id_valid,
    input  logic [31:0]            if_id_instr,
    input  logic [31:0]            if_id_pc4,
    input  logic                   flush,
    output logic [4:0]             rf_rd1,
    output logic [4:0]             rf_rd2,
    input  logic [31:0]            rf_A,
    input  logic [31:0]            rf_B,
    output logic                   stall_if,
    output logic                   ex_valid,
    output logic [31:0]            ex_A,
    output logic [31:0]            ex_B,
    output logic [31:0]            ex_imm,
    output logic [4:0]             ex_rs,
    output logic [4:0]             ex_rt,
    output logic [4:0]             ex_dst,
    output logic                   ex_regwrite,
    output logic                   ex_memread,
    output logic                   ex_memwrite,
    output logic                   ex_memtoreg,
    output logic                   ex_alusrc,
    output logic                   ex_branch,
    output logic [2:0]             ex_aluop,
    output logic [31:0]            ex_pc4,
    output logic                   ex_illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic        branch;
        logic [2:0]  aluop;
        logic        illegal;
    } idex_t;

    idex_t                  idex_q, idex_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;

    assign op    = if_id_instr[31:26];
    assign rs    = if_id_instr[25:21];
    assign rt    = if_id_instr[20:16];
    assign rd    = if_id_instr[15:11];
    assign shamt = if_id_instr[10:6];
    assign funct = if_id_instr[5:0];
    assign imm16 = if_id_instr[15:0];

    assign rf_rd1 = rs;
    assign rf_rd2 = rt;

    logic [31:0] dec_imm;
    logic [4:0]  dec_dst;
    logic        dec_regwrite, dec_memread, dec_memwrite, dec_memtoreg;
    logic        dec_alusrc, dec_branch, dec_illegal, dec_reads_rt;
    logic [2:0]  dec_aluop;

    always_comb begin
        dec_imm      = '0;
        dec_dst      = '0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_alusrc   = 1'b0;
        dec_branch   = 1'b0;
        dec_aluop    = ALU_ADD;
        dec_illegal  = 1'b0;
        dec_reads_rt = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                dec_reads_rt = 1'b1;
                dec_dst      = rd;
                dec_regwrite = 1'b1;
                dec_imm      = {27'b0, shamt};
                case (funct)
                    6'h20:   dec_aluop = ALU_ADD;
                    6'h22:   dec_aluop = ALU_SUB;
                    6'h24:   dec_aluop = ALU_AND;
                    6'h25:   dec_aluop = ALU_OR;
                    6'h2A:   dec_aluop = ALU_SLT;
                    6'h00:   dec_aluop = ALU_SLL;
                    default: begin
                        dec_illegal  = 1'b1;
                        dec_dst      = '0;
                        dec_regwrite = 1'b0;
                        dec_imm      = '0;
                    end
                endcase
            end
            OP_ADDI, OP_LW: begin
                dec_imm      = {{16{imm16[15]}}, imm16};
                dec_alusrc   = 1'b1;
                dec_dst      = rt;
                dec_regwrite = 1'b1;
                dec_memread  = (op == OP_LW);
                dec_memtoreg = (op == OP_LW);
            end
            OP_ANDI, OP_ORI: begin
                dec_imm      = {16'b0, imm16};
                dec_alusrc   = 1'b1;
                dec_dst      = rt;
                dec_regwrite = 1'b1;
                dec_aluop    = (op == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            OP_SW: begin
                dec_imm      = {{16{imm16[15]}}, imm16};
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
                dec_reads_rt = 1'b1;
            end
            OP_BEQ: begin
                dec_imm      = {{16{imm16[15]}}, imm16};
                dec_aluop    = ALU_SUB;
                dec_branch   = 1'b1;
                dec_reads_rt = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Writes to $0 are architecturally discarded, so never request them.
        if (dec_dst == 5'd0) begin
            dec_regwrite = 1'b0;
        end
    end

    logic hazard;

    assign hazard = if_id_valid & idex_q.valid & idex_q.memread & (idex_q.dst != 5'd0) &
                    ((idex_q.dst == rs) | ((idex_q.dst == rt) & dec_reads_rt));

    assign stall_if = hazard & ~flush & rst_n;

    always_comb begin
        idex_d      = '0;
        stall_cnt_d = stall_cnt_q;
        if (!rst_n) begin
            stall_cnt_d = '0;
        end else if (flush) begin
            idex_d = '0;
        end else if (hazard) begin
            // Bubble clears memread, so the stall releases on the next cycle.
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end else begin
            idex_d.valid = if_id_valid;
            idex_d.a     = rf_A;
            idex_d.b     = rf_B;
            idex_d.imm   = dec_imm;
            idex_d.pc4   = if_id_pc4;
            idex_d.rs    = rs;
            idex_d.rt    = rt;
            idex_d.dst   = dec_dst;
            if (if_id_valid) begin
                idex_d.regwrite = dec_regwrite;
                idex_d.memread  = dec_memread;
                idex_d.memwrite = dec_memwrite;
                idex_d.memtoreg = dec_memtoreg;
                idex_d.alusrc   = dec_alusrc;
                idex_d.branch   = dec_branch;
                idex_d.aluop    = dec_aluop;
                idex_d.illegal  = dec_illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        idex_q      <= idex_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign ex_valid    = idex_q.valid;
    assign ex_A        = idex_q.a;
    assign ex_B        = idex_q.b;
    assign ex_imm      = idex_q.imm;
    assign ex_pc4      = idex_q.pc4;
    assign ex_rs       = idex_q.rs;
    assign ex_rt       = idex_q.rt;
    assign ex_dst      = idex_q.dst;
    assign ex_regwrite = idex_q.regwrite;
    assign ex_memread  = idex_q.memread;
    assign ex_memwrite = idex_q.memwrite;
    assign ex_memtoreg = idex_q.memtoreg;
    assign ex_alusrc   = idex_q.alusrc;
    assign ex_branch   = idex_q.branch;
    assign ex_aluop    = idex_q.aluop;
    assign ex_illegal  = idex_q.illegal;
    assign stall_count = stall_cnt_q;

endmodule
